// File: rtl/regfile_mp_init.sv
// Multi-port register file with registered reads, write-first bypass and init sequencer.
// Optional REGFILE_ZERO_REG_EN: entry 0 reads as zero and ignores writes.
module regfile_mp_init #(
    parameter int              SIZE       = 16,
    parameter int              DEPTH      = 8,
    parameter int              NREAD      = 2,
    parameter logic [SIZE-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    write_en,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SIZE-1:0]         write_data,
    input  logic [NREAD-1:0]        ren,
    input  logic [NREAD*$clog2(DEPTH)-1:0] raddr,
    output logic [NREAD*SIZE-1:0]   read_data,
    output logic [NREAD-1:0]        rvalid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           init_ptr_q, init_ptr_d;
    logic [NREAD*SIZE-1:0]   rdata_q, rdata_d;
    logic [NREAD-1:0]        rvalid_q, rvalid_d;
    logic [SIZE-1:0]         mem_q [DEPTH];

    logic                    mem_we;
    logic [AW-1:0]           mem_wa;
    logic [SIZE-1:0]         mem_wd;
    logic                    wr_ok;
    logic [AW-1:0]           ra;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rdata_d    = rdata_q;
        rvalid_d   = '0;
        mem_we     = 1'b0;
        mem_wa     = waddr;
        mem_wd     = write_data;
        wr_ok      = 1'b0;
        ra         = '0;
        unique case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_wa     = init_ptr_q;
                mem_wd     = INIT_VALUE;
                init_ptr_d = init_ptr_q + AW'(1);
                rdata_d    = '0;
                if (init_ptr_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // A clr cycle drops its write, so it must not feed the bypass either.
                wr_ok  = write_en && !clr && in_range(waddr)
                         && !is_zero_reg(waddr);
                mem_we = wr_ok;
                if (clr) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end
                for (int i = 0; i < NREAD; i++) begin
                    ra          = raddr[i*AW +: AW];
                    rvalid_d[i] = ren[i];
                    if (ren[i]) begin
                        if (!in_range(ra) || is_zero_reg(ra)) begin
                            rdata_d[i*SIZE +: SIZE] = '0;
                        end else if (wr_ok && waddr == ra) begin
                            rdata_d[i*SIZE +: SIZE] = write_data;
                        end else begin
                            rdata_d[i*SIZE +: SIZE] = mem_q[ra];
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Storage is cleared by the sequencer, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign busy      = (state_q == ST_INIT);
    assign read_data = rdata_q;
    assign rvalid    = rvalid_q;

endmodule

// File: tb/tb_regfile_mp_init.sv
// Directed bench for regfile_mp_init: an 8-entry 2-port instance
// and a 6-entry 1-port instance for out-of-range addressing.
module tb_regfile_mp_init;

    localparam logic [15:0] IV  = 16'h5A3C;
    localparam logic [15:0] IV2 = 16'h0F0F;
`ifdef REGFILE_ZERO_REG_EN
    localparam logic [15:0] ZEXP = 16'h0000;
`else
    localparam logic [15:0] ZEXP = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        clr, busy, write_en;
    logic [2:0]  waddr;
    logic [15:0] write_data;
    logic [1:0]  ren, rvalid;
    logic [5:0]  raddr;
    logic [31:0] read_data;

    logic        clr2, busy2, we2;
    logic [2:0]  waddr2, raddr2;
    logic [15:0] wdata2, rdata2;
    logic [0:0]  ren2, rvalid2;

    int checks = 0;
    int errors = 0;

    regfile_mp_init #(
        .SIZE(16), .DEPTH(8), .NREAD(2), .INIT_VALUE(IV)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .write_en(write_en), .waddr(waddr), .write_data(write_data),
        .ren(ren), .raddr(raddr), .read_data(read_data), .rvalid(rvalid)
    );

    regfile_mp_init #(
        .SIZE(16), .DEPTH(6), .NREAD(1), .INIT_VALUE(IV2)
    ) u_dut6 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .busy(busy2),
        .write_en(we2), .waddr(waddr2), .write_data(wdata2),
        .ren(ren2), .raddr(raddr2), .read_data(rdata2), .rvalid(rvalid2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag, input int n0);
        int n = n0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 0; write_en = 0; waddr = 0; write_data = 0;
        ren = 0; raddr = 0;
        clr2 = 0; we2 = 0; waddr2 = 0; wdata2 = 0;
        ren2 = 0; raddr2 = 0;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_data", read_data, 0);

        rst_n = 1;
        wait_init("init_len", 0);
        check("d6_ready", busy2, 0);

        for (int a = 0; a < 8; a++) begin
            ren = 2'b01;
            raddr = {3'd0, 3'(a)};
            tick();
            check("init_rd", {rvalid, read_data[15:0]}, {2'b01, IV});
        end
        ren = 2'b00;
        tick();
        check("ren_off_hold", {rvalid, read_data[15:0]}, {2'b00, IV});

        write_en = 1; waddr = 3; write_data = 16'hBEEF;
        ren = 2'b01; raddr = {3'd0, 3'd3};
        tick();
        write_en = 0;
        check("bypass", {rvalid[0], read_data[15:0]}, {1'b1, 16'hBEEF});
        ren = 2'b10; raddr = {3'd3, 3'd0};
        tick();
        check("rd_after_wr", {rvalid, read_data[31:16]}, {2'b10, 16'hBEEF});

        ren = 0;
        write_en = 1; waddr = 5; write_data = 16'h1234;
        tick();
        waddr = 6; write_data = 16'h5678;
        tick();
        write_en = 0;
        ren = 2'b11; raddr = {3'd6, 3'd5};
        tick();
        check("dual_rd", read_data, {16'h5678, 16'h1234});
        raddr = {3'd6, 3'd6};
        tick();
        check("same_addr", {rvalid, read_data}, {2'b11, 16'h5678, 16'h5678});
        ren = 0;

        ren2 = 1; raddr2 = 1;
        tick();
        check("d6_rd1", rdata2, IV2);
        we2 = 1; waddr2 = 7; wdata2 = 16'h1111; raddr2 = 7;
        tick();
        we2 = 0;
        check("d6_oor_rd", {rvalid2, rdata2}, {1'b1, 16'h0000});
        for (int a = 0; a < 6; a++) begin
            raddr2 = 3'(a);
            tick();
            check("d6_unchanged", rdata2, IV2);
        end
        ren2 = 0;

        write_en = 1; waddr = 2; write_data = 16'hAAAA;
        tick();
        clr = 1; waddr = 4; write_data = 16'h4444;
        ren = 2'b01; raddr = {3'd0, 3'd2};
        tick();
        clr = 0; ren = 0;
        waddr = 2; write_data = 16'h7777;
        check("clr_busy", busy, 1);
        check("clr_rd_done", {rvalid, read_data[15:0]}, {2'b01, 16'hAAAA});
        tick();
        check("init_rd_zero", {rvalid, read_data}, 34'h0);
        wait_init("clr_len", 1);
        write_en = 0;
        ren = 2'b11; raddr = {3'd4, 3'd2};
        tick();
        check("clr_cleared", read_data, {IV, IV});

        write_en = 1; waddr = 0; write_data = 16'hFFFF;
        ren = 2'b01; raddr = 6'd0;
        tick();
        write_en = 0;
        check("reg0_bypass", read_data[15:0], ZEXP);
        tick();
        check("reg0_read", read_data[15:0], ZEXP);

        write_en = 1; waddr = 5; write_data = 16'h1234;
        ren = 0;
        tick();
        write_en = 0;
        ren = 2'b11; raddr = {3'd5, 3'd5};
        tick();
        ren = 0;
        rst_n = 0;
        #1;
        check("rst_mid_rd", {busy, rvalid, read_data}, {1'b1, 2'b00, 32'h0});
        tick();
        rst_n = 1;
        repeat (4) tick();
        rst_n = 0;
        repeat (2) tick();
        check("rst_mid_init", busy, 1);
        rst_n = 1;
        wait_init("reinit_len", 0);
        ren = 2'b11; raddr = {3'd5, 3'd7};
        tick();
        check("reinit_rd", read_data, {IV, IV});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
